// File: rtl/nvram_saver_pkg.sv
// Shared types and helpers for the NVRAM save streamer.
// Save lengths are byte counts of the cartridge backup RAM.
package nvram_saver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam int          LEN_W    = 16;
  localparam logic [15:0] SIZE_8K  = 16'd8192;
  localparam logic [15:0] SIZE_16K = 16'd16384;
  localparam logic [15:0] SIZE_32K = 16'd32768;

  // Any size_sel with the upper bit set selects the full 32 KB image.
  function automatic logic [LEN_W-1:0] len_from_sel(input logic [1:0] size_sel);
    logic [LEN_W-1:0] len;
    case (size_sel)
      2'b00:   len = SIZE_8K;
      2'b01:   len = SIZE_16K;
      default: len = SIZE_32K;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/nvram_saver_quiet_timer.sv
// Quiet-period timer: counts enabled cycles since the last clear and
// holds expired high, saturated, until the next clear.
module nvram_quiet_timer
  import nvram_saver_pkg::*;
#(
  parameter int AUTOSAVE_CYCLES = 53_700_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (AUTOSAVE_CYCLES > 2) ? $clog2(AUTOSAVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(AUTOSAVE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (count_en && (cnt_reg != LAST)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/nvram_saver.sv
// Streams the backup NVRAM out through RAM port b, one byte per handshake,
// either on request or automatically after system writes go quiet.
module nvram_saver
  import nvram_saver_pkg::*;
#(
  parameter int ADDR_W          = 15,
  parameter int AUTOSAVE_CYCLES = 53_700_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              nvram_we,
  input  logic              autosave_en,
  input  logic              save_req,
  input  logic              abort,
  input  logic [1:0]        size_sel,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              saving,
  output logic              done,
  output logic              dirty
);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  ram_addr_reg, ram_addr_next;
  logic [LEN_W-1:0]   count_reg, count_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [7:0]         dout_reg, dout_next;
  logic               dout_valid_reg, dout_valid_next;
  logic               saving_reg, saving_next;
  logic               done_reg, done_next;
  logic               dirty_reg, dirty_next;
  logic               redirty_reg, redirty_next;

  logic timer_clear;
  logic timer_count_en;
  logic autosave_trig;

  // The quiet period only runs in IDLE; any active save restarts it from zero.
  assign timer_clear    = nvram_we || !autosave_en || (state_reg != IDLE);
  assign timer_count_en = dirty_reg && autosave_en && (state_reg == IDLE);

  nvram_quiet_timer #(
    .AUTOSAVE_CYCLES(AUTOSAVE_CYCLES)
  ) u_quiet_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .count_en(timer_count_en),
    .expired (autosave_trig)
  );

  always_comb begin
    state_next      = state_reg;
    ram_addr_next   = ram_addr_reg;
    count_next      = count_reg;
    len_next        = len_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    saving_next     = saving_reg;
    done_next       = 1'b0;
    dirty_next      = dirty_reg | nvram_we;
    redirty_next    = redirty_reg | (nvram_we && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (save_req || autosave_trig) begin
          state_next    = ADDR;
          ram_addr_next = '0;
          count_next    = '0;
          len_next      = len_from_sel(size_sel);
          redirty_next  = 1'b0;
          saving_next   = 1'b1;
        end
      end
      ADDR: begin
        state_next = WAIT;
      end
      WAIT: begin
        dout_next       = ram_q;
        dout_valid_next = 1'b1;
        state_next      = SEND;
      end
      SEND: begin
        if (dout_ready) begin
          dout_valid_next = 1'b0;
          if (count_reg == len_reg - LEN_W'(1)) begin
            // A write seen at any point during the save keeps the image stale.
            state_next  = DONE;
            done_next   = 1'b1;
            saving_next = 1'b0;
            dirty_next  = redirty_reg | nvram_we;
          end else begin
            count_next    = count_reg + LEN_W'(1);
            ram_addr_next = ram_addr_reg + ADDR_W'(1);
            state_next    = ADDR;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over a handshake completing in the same cycle.
    if (abort && (state_reg != IDLE)) begin
      state_next      = IDLE;
      dout_valid_next = 1'b0;
      saving_next     = 1'b0;
      done_next       = 1'b0;
      dirty_next      = dirty_reg | nvram_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      ram_addr_reg   <= '0;
      count_reg      <= '0;
      len_reg        <= SIZE_8K;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      saving_reg     <= 1'b0;
      done_reg       <= 1'b0;
      dirty_reg      <= 1'b0;
      redirty_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ram_addr_reg   <= ram_addr_next;
      count_reg      <= count_next;
      len_reg        <= len_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      saving_reg     <= saving_next;
      done_reg       <= done_next;
      dirty_reg      <= dirty_next;
      redirty_reg    <= redirty_next;
    end
  end

  assign ram_addr   = ram_addr_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign saving     = saving_reg;
  assign done       = done_reg;
  assign dirty      = dirty_reg;

endmodule

// File: doc/nvram_saver.md
Name: nvram_saver

Overview:
- Reads the 32 KB cartridge-backup NVRAM through its second dual-port RAM port, and streams it byte-by-byte to the MCU I/O system for saving to SD card.
- It is the reader counterpart of the system's NVRAM writer.
- It tracks a dirty flag from system-side NVRAM writes and starts an autosave once writes have been quiet for a set period.
- It also accepts an explicit save request.

Parameters:
ADDR_W, 15, NVRAM address width (32 KB).
AUTOSAVE_CYCLES, 53_700_000, quiet clk cycles after the last NVRAM write before an autosave starts (1 s at 53.7 MHz).

Ports:
clk  in  1  system clock (clk_sys domain)
resetn  in  1  synchronous active-low reset
nvram_we  in  1  system-side NVRAM write strobe (monitor only)
autosave_en  in  1  enables the quiet-timer autosave
save_req  in  1  one-cycle pulse: save now
abort  in  1  one-cycle pulse: cancel a save in progress
size_sel  in  2  save length: 00=8 KB, 01=16 KB, 1x=32 KB
ram_addr  out  ADDR_W  dual-port RAM port-b address
ram_q  in  8  dual-port RAM port-b read data, registered, valid 1 cycle after ram_addr
dout  out  8  stream byte
dout_valid  out  1  stream valid
dout_ready  in  1  stream ready (MCU side)
saving  out  1  high while a save is active
done  out  1  one-cycle pulse after the last byte is accepted
dirty  out  1  NVRAM modified since the last completed save

Behaviour:
- One clock; reset is synchronous and active-low. Every register is sampled on posedge clk while resetn=0.
- Reset values:
  - ram_addr=0, dout=0, dout_valid=0, saving=0, done=0, dirty=0.
  - Byte counter = 0, quiet timer = 0, state = IDLE.
- Reset mid-save abandons the save immediately, with no done pulse.
- Length: len = 8192 << min(size_sel,2). size_sel is latched when a save starts and ignored mid-save.
- Dirty tracking:
  - nvram_we=1 sets dirty in every state.
  - A completed save clears dirty at the done cycle, unless nvram_we was seen at any point during that save (redirty flag). In that case dirty stays 1 and the quiet timer restarts.
- Quiet timer (IDLE only):
  - Counts while dirty && autosave_en.
  - Resets to 0 on nvram_we or when autosave_en=0.
  - Reaching AUTOSAVE_CYCLES-1 raises the autosave trigger.
- Start condition in IDLE: save_req OR autosave trigger.
  - If both occur in the same cycle, exactly one save starts.
  - save_req starts a save even when dirty=0.
  - save_req while saving=1 is ignored.
- State machine:
  - IDLE: on start, set ram_addr=0, count=0, clear redirty, saving=1, go to ADDR.
  - ADDR: ram_addr holds the current address; go to WAIT (RAM latency cycle).
  - WAIT: capture dout<=ram_q, dout_valid<=1, go to SEND.
  - SEND:
    - dout and dout_valid are held stable while dout_ready=0.
    - On dout_valid && dout_ready, drop valid.
    - If count==len-1: go to DONE. Otherwise increment count and ram_addr, then go to ADDR.
  - DONE: done=1 for one cycle, saving=0, update dirty as above, go to IDLE.
- Throughput is at most one byte per 3 cycles. Zero-wait ready is allowed (valid and ready both high in the first SEND cycle).
- abort in any non-IDLE state:
  - Next cycle: IDLE, dout_valid=0, saving=0, no done pulse.
  - dirty is unchanged (it stays set).
  - abort and reset both take precedence over handshake completion in the same cycle.
- Arithmetic:
  - Byte counter is 16 bits (len up to 32768).
  - ram_addr wraps modulo 2^ADDR_W; wrap never occurs within a legal len.
  - Quiet timer is $clog2(AUTOSAVE_CYCLES) bits and saturates when it reaches the trigger.

Decomposition:
- Package nvram_saver_pkg:
  - state enum {IDLE, ADDR, WAIT, SEND, DONE}
  - SIZE_8K/16K/32K localparams
  - function len_from_sel(size_sel) returning 16-bit length
- Sub-module nvram_quiet_timer, parameterised by AUTOSAVE_CYCLES.
  - Inputs: clk, resetn, clear, count_en.
  - Output: expired (level until clear).

Test Plan:
- Manual 8 KB save: RAM preloaded with byte = addr[7:0]^addr[12:8]; size_sel=00, dout_ready=1, save_req pulse. Expect exactly 8192 beats with dout matching the pattern, a single done pulse, saving low after done, dirty=0.
- Backpressure: 16 KB save with dout_ready toggling pseudo-randomly. Expect 16384 beats in order, dout stable during every valid&&!ready cycle, no duplicates or drops.
- Autosave: AUTOSAVE_CYCLES=100, autosave_en=1, nvram_we at cycle 0 and again at cycle 50. Expect saving to rise at cycle 150±2, not before; with autosave_en=0, no save ever starts.
- Redirty and abort:
  - nvram_we mid-save: expect dirty=1 after done and a second autosave after the quiet period.
  - abort at byte 1000: expect valid=0 next cycle, no done pulse, dirty still 1.
- Start collisions and reset: save_req coincident with the autosave trigger gives exactly one save. save_req while saving is ignored (byte count unchanged). resetn=0 at byte 500 gives all outputs at reset values next cycle and no done pulse.
